// File: rtl/wt_cache_pkg.sv
// Shared types for the instruction-cache refill path.
// Contents: physical address / transaction id widths, refill slot state
// enum, refill request payload struct and an address alignment helper.
package wt_cache_pkg;

   localparam int unsigned PLEN           = 56;
   localparam int unsigned CACHE_ID_WIDTH = 4;

   typedef enum logic [1:0] {
      SLOT_FREE,
      SLOT_AR_PEND,
      SLOT_DATA,
      SLOT_DONE
   } refill_slot_e;

   typedef struct packed {
      logic [PLEN-1:0]           paddr;
      logic                      nc;
      logic [CACHE_ID_WIDTH-1:0] tid;
   } refill_req_t;

   // Clear the low address bits below a power-of-two byte boundary.
   function automatic logic [PLEN-1:0] align_addr(input logic [PLEN-1:0] addr,
                                                  input int unsigned     bytes);
      return addr & ~PLEN'(bytes - 1);
   endfunction

endpackage

// File: rtl/icache_refill_slot.sv
// One outstanding refill: line buffer, beat counter, requester tid and
// (with ICACHE_REFILL_ERR_EN defined) a sticky bus-error flag.
// Ports: clk_i/rst_ni; alloc_i/alloc_tid_i clear the slot and capture the tid;
// beat_i/beat_last_i/beat_data_i/beat_err_i write one R beat;
// line_o/tid_o/err_o present the slot contents.
module icache_refill_slot
   import wt_cache_pkg::*;
#(
   parameter int unsigned LineWidth    = 256,
   parameter int unsigned AxiDataWidth = 64
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      alloc_i,
   input  logic [CACHE_ID_WIDTH-1:0] alloc_tid_i,
   input  logic                      beat_i,
   input  logic                      beat_last_i,
   input  logic [AxiDataWidth-1:0]   beat_data_i,
   input  logic                      beat_err_i,
   output logic [LineWidth-1:0]      line_o,
   output logic [CACHE_ID_WIDTH-1:0] tid_o,
   output logic                      err_o
);

   localparam int unsigned NumBeats = LineWidth / AxiDataWidth;
   localparam int unsigned CntWidth = (NumBeats > 1) ? $clog2(NumBeats) : 1;

   logic [LineWidth-1:0]      line_d, line_q;
   logic [CntWidth-1:0]       cnt_d, cnt_q;
   logic [CACHE_ID_WIDTH-1:0] tid_q;

   // Beat placement; allocation zeroes the buffer so a single nc beat leaves upper bits clear.
   always_comb begin
      line_d = line_q;
      cnt_d  = cnt_q;
      if (alloc_i) begin
         line_d = '0;
         cnt_d  = '0;
      end else if (beat_i) begin
         for (int unsigned b = 0; b < NumBeats; b++) begin
            if (cnt_q == CntWidth'(b)) line_d[b*AxiDataWidth +: AxiDataWidth] = beat_data_i;
         end
         cnt_d = (beat_last_i || cnt_q == CntWidth'(NumBeats - 1)) ? '0 : cnt_q + CntWidth'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         line_q <= '0;
         cnt_q  <= '0;
         tid_q  <= '0;
      end else begin
         line_q <= line_d;
         cnt_q  <= cnt_d;
         if (alloc_i) tid_q <= alloc_tid_i;
      end
   end

   assign line_o = line_q;
   assign tid_o  = tid_q;

`ifdef ICACHE_REFILL_ERR_EN
   logic err_q;

   // Error accumulates over the whole burst and clears on the next allocation.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                    err_q <= 1'b0;
      else if (alloc_i)               err_q <= 1'b0;
      else if (beat_i && beat_err_i)  err_q <= 1'b1;
   end

   assign err_o = err_q;
`else
   logic unused_err;
   assign unused_err = beat_err_i;
   assign err_o      = 1'b0;
`endif

endmodule

// File: rtl/icache_axi_refill.sv
// Instruction-cache miss refill engine over AXI AR/R with NumSlots
// outstanding refills, per-slot line assembly and a single return register.
// Ports: req_* miss request in; ar_* AXI read address out; r_* AXI read data in;
// rtrn_* assembled line out. Optional macro ICACHE_REFILL_ERR_EN enables
// bus-error reporting on rtrn_err_o (otherwise tied to 0).
module icache_axi_refill
   import wt_cache_pkg::*;
#(
   parameter int unsigned LineWidth    = 256,
   parameter int unsigned AxiDataWidth = 64,
   parameter int unsigned AxiIdWidth   = 4,
   parameter int unsigned NumSlots     = 2
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      req_valid_i,
   output logic                      req_ready_o,
   input  logic [PLEN-1:0]           req_paddr_i,
   input  logic                      req_nc_i,
   input  logic [CACHE_ID_WIDTH-1:0] req_tid_i,
   output logic                      ar_valid_o,
   input  logic                      ar_ready_i,
   output logic [PLEN-1:0]           ar_addr_o,
   output logic [7:0]                ar_len_o,
   output logic [2:0]                ar_size_o,
   output logic [AxiIdWidth-1:0]     ar_id_o,
   input  logic                      r_valid_i,
   output logic                      r_ready_o,
   input  logic [AxiDataWidth-1:0]   r_data_i,
   input  logic [AxiIdWidth-1:0]     r_id_i,
   input  logic                      r_last_i,
   input  logic [1:0]                r_resp_i,
   output logic                      rtrn_valid_o,
   input  logic                      rtrn_ready_i,
   output logic [LineWidth-1:0]      rtrn_data_o,
   output logic [CACHE_ID_WIDTH-1:0] rtrn_tid_o,
   output logic                      rtrn_err_o
);

   localparam int unsigned NumBeats  = LineWidth / AxiDataWidth;
   localparam int unsigned LineBytes = LineWidth / 8;
   localparam int unsigned BeatBytes = AxiDataWidth / 8;
   localparam int unsigned SlotIdxW  = (NumSlots > 1) ? $clog2(NumSlots) : 1;

   refill_req_t               req;
   refill_slot_e              slot_q [NumSlots];
   logic [LineWidth-1:0]      slot_line [NumSlots];
   logic [CACHE_ID_WIDTH-1:0] slot_tid [NumSlots];
   logic [NumSlots-1:0]       slot_err, slot_alloc, slot_beat;

   logic                  free_avail, pend_any, done_any, r_hit;
   logic [SlotIdxW-1:0]   free_idx, done_idx;
   logic                  req_fire, ar_fire, r_fire, rtrn_load;

   logic                      ar_valid_q;
   logic [PLEN-1:0]           ar_addr_q;
   logic [7:0]                ar_len_q;
   logic [AxiIdWidth-1:0]     ar_id_q;
   logic                      rtrn_valid_q;
   logic [LineWidth-1:0]      rtrn_data_q;
   logic [CACHE_ID_WIDTH-1:0] rtrn_tid_q;
   logic                      rtrn_err_q;

   logic unused_resp;
   assign unused_resp = r_resp_i[0];

   assign req = '{paddr: req_paddr_i, nc: req_nc_i, tid: req_tid_i};

   // Slot scan; descending loop so the lowest index wins for FREE and DONE.
   always_comb begin
      free_avail = 1'b0;
      pend_any   = 1'b0;
      done_any   = 1'b0;
      r_hit      = 1'b0;
      free_idx   = '0;
      done_idx   = '0;
      for (int i = int'(NumSlots) - 1; i >= 0; i--) begin
         if (slot_q[i] == SLOT_FREE) begin
            free_avail = 1'b1;
            free_idx   = SlotIdxW'(i);
         end
         if (slot_q[i] == SLOT_AR_PEND) pend_any = 1'b1;
         if (slot_q[i] == SLOT_DONE) begin
            done_any = 1'b1;
            done_idx = SlotIdxW'(i);
         end
         if (slot_q[i] == SLOT_DATA && r_id_i == AxiIdWidth'(i)) r_hit = 1'b1;
      end
   end

   assign req_ready_o = free_avail & ~pend_any;
   assign req_fire    = req_valid_i & req_ready_o;
   assign ar_fire     = ar_valid_q & ar_ready_i;
   // Stall only a completing beat while a finished line is still parked in a slot.
   assign r_ready_o   = ~(r_valid_i & r_last_i & r_hit & done_any);
   assign r_fire      = r_valid_i & r_ready_o;
   assign rtrn_load   = done_any & (~rtrn_valid_q | rtrn_ready_i);

   for (genvar g = 0; g < NumSlots; g++) begin : gen_slot
      assign slot_alloc[g] = req_fire & (free_idx == SlotIdxW'(g));
      // Beats for slots not in DATA fall through here and are discarded.
      assign slot_beat[g]  = r_fire & (slot_q[g] == SLOT_DATA) & (r_id_i == AxiIdWidth'(g));

      icache_refill_slot #(
         .LineWidth    (LineWidth),
         .AxiDataWidth (AxiDataWidth)
      ) i_slot (
         .clk_i       (clk_i),
         .rst_ni      (rst_ni),
         .alloc_i     (slot_alloc[g]),
         .alloc_tid_i (req.tid),
         .beat_i      (slot_beat[g]),
         .beat_last_i (r_last_i),
         .beat_data_i (r_data_i),
         .beat_err_i  (r_resp_i[1]),
         .line_o      (slot_line[g]),
         .tid_o       (slot_tid[g]),
         .err_o       (slot_err[g])
      );
   end

   // Slot FSMs, AR channel and return register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(NumSlots); i++) slot_q[i] <= SLOT_FREE;
         ar_valid_q   <= 1'b0;
         ar_addr_q    <= '0;
         ar_len_q     <= '0;
         ar_id_q      <= '0;
         rtrn_valid_q <= 1'b0;
         rtrn_data_q  <= '0;
         rtrn_tid_q   <= '0;
         rtrn_err_q   <= 1'b0;
      end else begin
         for (int i = 0; i < int'(NumSlots); i++) begin
            case (slot_q[i])
               SLOT_FREE:    if (slot_alloc[i]) slot_q[i] <= SLOT_AR_PEND;
               SLOT_AR_PEND: if (ar_fire) slot_q[i] <= SLOT_DATA;
               SLOT_DATA:    if (slot_beat[i] && r_last_i) slot_q[i] <= SLOT_DONE;
               SLOT_DONE:    if (rtrn_load && done_idx == SlotIdxW'(i)) slot_q[i] <= SLOT_FREE;
               default:      slot_q[i] <= SLOT_FREE;
            endcase
         end

         // Acceptance requires no AR_PEND slot, so it never overlaps an AR handshake.
         if (req_fire) begin
            ar_valid_q <= 1'b1;
            ar_addr_q  <= req.nc ? align_addr(req.paddr, BeatBytes) : align_addr(req.paddr, LineBytes);
            ar_len_q   <= req.nc ? 8'd0 : 8'(NumBeats - 1);
            ar_id_q    <= AxiIdWidth'(free_idx);
         end else if (ar_fire) begin
            ar_valid_q <= 1'b0;
         end

         if (rtrn_load) begin
            rtrn_valid_q <= 1'b1;
            rtrn_data_q  <= slot_line[done_idx];
            rtrn_tid_q   <= slot_tid[done_idx];
            rtrn_err_q   <= slot_err[done_idx];
         end else if (rtrn_ready_i) begin
            rtrn_valid_q <= 1'b0;
         end
      end
   end

   assign ar_valid_o   = ar_valid_q;
   assign ar_addr_o    = ar_addr_q;
   assign ar_len_o     = ar_len_q;
   assign ar_size_o    = 3'($clog2(BeatBytes));
   assign ar_id_o      = ar_id_q;
   assign rtrn_valid_o = rtrn_valid_q;
   assign rtrn_data_o  = rtrn_data_q;
   assign rtrn_tid_o   = rtrn_tid_q;
   assign rtrn_err_o   = rtrn_err_q;

endmodule

// File: tb/tb_icache_axi_refill.sv
// Scoreboard bench for icache_axi_refill: randomized requests, AR and R
// slave behaviour and return backpressure, with expected AR and line
// responses produced by a transaction-level memory model.
module tb_icache_axi_refill;
   import wt_cache_pkg::*;

   localparam int unsigned LW   = 256;
   localparam int unsigned DW   = 64;
   localparam int unsigned IW   = 4;
   localparam int unsigned NS   = 2;
   localparam int unsigned NB   = LW / DW;
   localparam int          NREQ = 40;

   logic                      clk_i = 1'b0;
   logic                      rst_ni;
   logic                      req_valid_i, req_ready_o, req_nc_i;
   logic [PLEN-1:0]           req_paddr_i;
   logic [CACHE_ID_WIDTH-1:0] req_tid_i;
   logic                      ar_valid_o, ar_ready_i;
   logic [PLEN-1:0]           ar_addr_o;
   logic [7:0]                ar_len_o;
   logic [2:0]                ar_size_o;
   logic [IW-1:0]             ar_id_o;
   logic                      r_valid_i, r_ready_o, r_last_i;
   logic [DW-1:0]             r_data_i;
   logic [IW-1:0]             r_id_i;
   logic [1:0]                r_resp_i;
   logic                      rtrn_valid_o, rtrn_ready_i, rtrn_err_o;
   logic [LW-1:0]             rtrn_data_o;
   logic [CACHE_ID_WIDTH-1:0] rtrn_tid_o;

   icache_axi_refill #(.LineWidth(LW), .AxiDataWidth(DW), .AxiIdWidth(IW), .NumSlots(NS)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_paddr_i(req_paddr_i),
      .req_nc_i(req_nc_i), .req_tid_i(req_tid_i),
      .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o),
      .ar_len_o(ar_len_o), .ar_size_o(ar_size_o), .ar_id_o(ar_id_o),
      .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_data_i(r_data_i), .r_id_i(r_id_i),
      .r_last_i(r_last_i), .r_resp_i(r_resp_i),
      .rtrn_valid_o(rtrn_valid_o), .rtrn_ready_i(rtrn_ready_i), .rtrn_data_o(rtrn_data_o),
      .rtrn_tid_o(rtrn_tid_o), .rtrn_err_o(rtrn_err_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct { logic [PLEN-1:0] paddr; logic nc; logic [CACHE_ID_WIDTH-1:0] tid; } stim_t;
   typedef struct { logic [PLEN-1:0] addr; logic [7:0] len; logic [CACHE_ID_WIDTH-1:0] tid; } exp_ar_t;
   typedef struct { logic [LW-1:0] data; logic [CACHE_ID_WIDTH-1:0] tid; logic err; } exp_rt_t;

   stim_t   stim_q[$];
   exp_ar_t ar_q[$];
   exp_rt_t rt_q[$];

   int n_checks = 0;
   int n_fail   = 0;
   int n_ret    = 0;
   bit stop     = 1'b0;

   // Memory-side view of each AXI id: open burst, beats seen, assembled line.
   bit                        bact [16];
   int                        bcnt [16];
   int                        blen [16];
   logic [LW-1:0]             bline[16];
   logic [CACHE_ID_WIDTH-1:0] btid [16];
   logic                      berr [16];

   function automatic void chk(string name, logic [LW-1:0] a, logic [LW-1:0] e);
      n_checks++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, a, e);
      end
   endfunction

   // Expected AR: address rounded down to the transfer size, burst covers the line.
   function automatic exp_ar_t model_ar(stim_t s);
      exp_ar_t     r;
      logic [63:0] a;
      logic [63:0] bytes;
      bytes = s.nc ? 64'(DW / 8) : 64'(LW / 8);
      a     = 64'(s.paddr);
      a     = a - (a % bytes);
      r.addr = PLEN'(a);
      r.len  = s.nc ? 8'd0 : 8'(NB - 1);
      r.tid  = s.tid;
      return r;
   endfunction

   task automatic run_req();
      bit    fired = 1'b0;
      stim_t s;
      while (!stop) begin
         @(negedge clk_i);
         if (fired) begin req_valid_i = 1'b0; fired = 1'b0; end
         if (!req_valid_i && stim_q.size() > 0 && $urandom_range(0, 3) != 0) begin
            s = stim_q.pop_front();
            req_paddr_i = s.paddr; req_nc_i = s.nc; req_tid_i = s.tid; req_valid_i = 1'b1;
         end
         #2;
         if (req_valid_i && req_ready_o) begin
            ar_q.push_back(model_ar(s));
            fired = 1'b1;
         end
      end
   endtask

   task automatic run_ar();
      bit              held = 1'b0;
      logic [PLEN-1:0] h_addr;
      logic [7:0]      h_len;
      logic [IW-1:0]   h_id;
      exp_ar_t         e;
      int              id;
      while (!stop) begin
         @(negedge clk_i);
         ar_ready_i = ($urandom_range(0, 2) != 0);
         #2;
         if (held) begin
            chk("ar_valid_hold", LW'(ar_valid_o), LW'(1));
            chk("ar_addr_stable", LW'(ar_addr_o), LW'(h_addr));
            chk("ar_len_stable", LW'(ar_len_o), LW'(h_len));
            chk("ar_id_stable", LW'(ar_id_o), LW'(h_id));
         end
         held = ar_valid_o && !ar_ready_i;
         h_addr = ar_addr_o; h_len = ar_len_o; h_id = ar_id_o;
         if (ar_valid_o && ar_ready_i) begin
            if (ar_q.size() == 0) begin
               chk("ar_unexpected", LW'(1), LW'(0));
            end else begin
               e  = ar_q.pop_front();
               id = int'(ar_id_o);
               chk("ar_addr", LW'(ar_addr_o), LW'(e.addr));
               chk("ar_len", LW'(ar_len_o), LW'(e.len));
               chk("ar_size", LW'(ar_size_o), LW'(3));
               chk("ar_id_range", LW'(id < int'(NS)), LW'(1));
               chk("ar_id_not_busy", LW'(bact[id]), LW'(0));
               bact[id] = 1'b1; bcnt[id] = 0; blen[id] = int'(e.len) + 1;
               bline[id] = '0; btid[id] = e.tid; berr[id] = 1'b0;
            end
         end
      end
   endtask

   task automatic run_r();
      bit      hold  = 1'b0;
      bit      stray = 1'b0;
      int      ids[$];
      int      id;
      exp_rt_t e;
      while (!stop) begin
         @(negedge clk_i);
         if (!hold) begin
            r_valid_i = 1'b0;
            ids.delete();
            for (int i = 0; i < 16; i++) if (bact[i]) ids.push_back(i);
            if (!stop && $urandom_range(0, 19) == 0) begin
               stray = 1'b1; r_valid_i = 1'b1; r_id_i = 4'hF;
               r_last_i = 1'($urandom_range(0, 1)); r_data_i = {$urandom, $urandom}; r_resp_i = 2'b00;
            end else if (ids.size() > 0 && $urandom_range(0, 3) != 0) begin
               stray = 1'b0;
               id = ids[$urandom_range(0, ids.size() - 1)];
               r_valid_i = 1'b1; r_id_i = IW'(id); r_data_i = {$urandom, $urandom};
               r_last_i = (bcnt[id] == blen[id] - 1);
               r_resp_i = ($urandom_range(0, 7) == 0) ? 2'b10 : {1'b0, 1'($urandom_range(0, 1))};
            end
         end
         #2;
         if (r_valid_i && !r_last_i) chk("r_ready_nonlast", LW'(r_ready_o), LW'(1));
         if (r_valid_i && stray) chk("r_ready_stray", LW'(r_ready_o), LW'(1));
         hold = r_valid_i && !r_ready_o;
         if (r_valid_i && r_ready_o) begin
            if (stray) begin
               $display("note: R beat for idle id %0d discarded", r_id_i);
            end else begin
               id = int'(r_id_i);
               bline[id][bcnt[id]*DW +: DW] = r_data_i;
               berr[id] = berr[id] | r_resp_i[1];
               bcnt[id]++;
               if (r_last_i) begin
                  bact[id] = 1'b0;
                  e.data = bline[id]; e.tid = btid[id];
`ifdef ICACHE_REFILL_ERR_EN
                  e.err = berr[id];
`else
                  e.err = 1'b0;
`endif
                  rt_q.push_back(e);
               end
            end
         end
      end
   endtask

   task automatic run_rtrn();
      int      cyc  = 0;
      bit      held = 1'b0;
      exp_rt_t h;
      exp_rt_t e;
      while (!stop) begin
         @(negedge clk_i);
         cyc++;
         // Periodic 20-cycle windows of no consumption force the R stall path.
         rtrn_ready_i = ((cyc % 120) < 20) ? 1'b0 : ($urandom_range(0, 3) != 0);
         #2;
         if (held) begin
            chk("rtrn_valid_hold", LW'(rtrn_valid_o), LW'(1));
            chk("rtrn_data_stable", rtrn_data_o, h.data);
            chk("rtrn_tid_stable", LW'(rtrn_tid_o), LW'(h.tid));
         end
         held = rtrn_valid_o && !rtrn_ready_i;
         h.data = rtrn_data_o; h.tid = rtrn_tid_o;
         if (rtrn_valid_o && rtrn_ready_i) begin
            if (rt_q.size() == 0) begin
               chk("rtrn_unexpected", LW'(1), LW'(0));
            end else begin
               e = rt_q.pop_front();
               chk("rtrn_data", rtrn_data_o, e.data);
               chk("rtrn_tid", LW'(rtrn_tid_o), LW'(e.tid));
               chk("rtrn_err", LW'(rtrn_err_o), LW'(e.err));
            end
            n_ret++;
         end
      end
   endtask

   task automatic run_phase(int target);
      int t = 0;
      stop = 1'b0;
      fork
         run_req();
         run_ar();
         run_r();
         run_rtrn();
      join_none
      while (n_ret < target && t < 20000) begin
         @(negedge clk_i);
         t++;
      end
      chk("lines_returned", LW'(n_ret), LW'(target));
      stop = 1'b1;
      repeat (4) @(negedge clk_i);
      chk("ar_queue_empty", LW'(ar_q.size()), LW'(0));
      chk("rtrn_queue_empty", LW'(rt_q.size()), LW'(0));
      req_valid_i = 1'b0; ar_ready_i = 1'b0; r_valid_i = 1'b0; rtrn_ready_i = 1'b0;
   endtask

   task automatic chk_reset_outputs(string tag);
      chk({tag, "_req_ready"}, LW'(req_ready_o), LW'(1));
      chk({tag, "_ar_valid"}, LW'(ar_valid_o), LW'(0));
      chk({tag, "_ar_addr"}, LW'(ar_addr_o), LW'(0));
      chk({tag, "_ar_len"}, LW'(ar_len_o), LW'(0));
      chk({tag, "_ar_id"}, LW'(ar_id_o), LW'(0));
      chk({tag, "_r_ready"}, LW'(r_ready_o), LW'(1));
      chk({tag, "_rtrn_valid"}, LW'(rtrn_valid_o), LW'(0));
      chk({tag, "_rtrn_data"}, rtrn_data_o, LW'(0));
      chk({tag, "_rtrn_tid"}, LW'(rtrn_tid_o), LW'(0));
      chk({tag, "_rtrn_err"}, LW'(rtrn_err_o), LW'(0));
   endtask

   initial begin
      stim_t s;
      rst_ni = 1'b0;
      req_valid_i = 1'b0; req_paddr_i = '0; req_nc_i = 1'b0; req_tid_i = '0;
      ar_ready_i = 1'b0; r_valid_i = 1'b0; r_data_i = '0; r_id_i = '0;
      r_last_i = 1'b0; r_resp_i = '0; rtrn_ready_i = 1'b0;
      for (int i = 0; i < 16; i++) begin
         bact[i] = 1'b0; bcnt[i] = 0; blen[i] = 0; bline[i] = '0; btid[i] = '0; berr[i] = 1'b0;
      end
      repeat (3) @(negedge clk_i);
      #2;
      chk_reset_outputs("reset");

      // Directed cacheable and non-cacheable misses first, then random traffic.
      s.paddr = PLEN'(64'h8000_1234); s.nc = 1'b0; s.tid = 4'd1; stim_q.push_back(s);
      s.paddr = PLEN'(64'h1000_0004); s.nc = 1'b1; s.tid = 4'd2; stim_q.push_back(s);
      for (int i = 2; i < NREQ; i++) begin
         s.paddr = PLEN'({$urandom, $urandom});
         s.nc    = ($urandom_range(0, 3) == 0);
         s.tid   = CACHE_ID_WIDTH'($urandom_range(0, 15));
         stim_q.push_back(s);
      end
      @(negedge clk_i);
      rst_ni = 1'b1;
      run_phase(NREQ);

      // Mid-burst reset: one request, AR handshake, one erroring beat, then reset.
      @(negedge clk_i);
      req_valid_i = 1'b1; req_paddr_i = PLEN'(64'h8000_0040); req_nc_i = 1'b0; req_tid_i = 4'd3;
      #2;
      chk("mid_req_ready", LW'(req_ready_o), LW'(1));
      @(negedge clk_i);
      req_valid_i = 1'b0;
      #2;
      chk("mid_ar_valid", LW'(ar_valid_o), LW'(1));
      chk("mid_ar_id_lowest", LW'(ar_id_o), LW'(0));
      chk("mid_ar_addr", LW'(ar_addr_o), LW'(64'h8000_0040));
      chk("mid_req_blocked", LW'(req_ready_o), LW'(0));
      @(negedge clk_i);
      ar_ready_i = 1'b1;
      @(negedge clk_i);
      ar_ready_i = 1'b0;
      r_valid_i = 1'b1; r_id_i = '0; r_data_i = 64'hDEAD_BEEF; r_last_i = 1'b0; r_resp_i = 2'b10;
      #2;
      chk("mid_r_ready", LW'(r_ready_o), LW'(1));
      @(negedge clk_i);
      r_valid_i = 1'b0; r_resp_i = 2'b00;
      rst_ni = 1'b0;
      #1;
      chk_reset_outputs("midreset");
      @(negedge clk_i);
      rst_ni = 1'b1;

      // Fresh traffic after the abandoned burst must assemble from beat 0.
      s.paddr = PLEN'(64'h8000_0040); s.nc = 1'b0; s.tid = 4'd5; stim_q.push_back(s);
      s.paddr = PLEN'(64'h2000_0018); s.nc = 1'b1; s.tid = 4'd6; stim_q.push_back(s);
      run_phase(NREQ + 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
